// File: rtl/serial_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_chunk_adder
//  Purpose  : Multi-cycle adder. Adds two WIDTH-bit operands plus a carry-in
//             CHUNK bits per clock using one CHUNK-bit adder slice and a
//             registered carry. Valid/ready handshakes on both sides.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid / in_ready / a / b / cin     - operand side
//             out_valid / out_ready / sum / cout    - result side
//             ovf (only with SERIAL_ADDER_OVF_EN)   - signed overflow flag
//  Options  : `define SERIAL_ADDER_OVF_EN to add the two's-complement
//             overflow output ovf, registered with the final chunk.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   a_sh_q,      a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,      b_sh_d;
    logic [WIDTH-1:0]   sum_q,       sum_d;
    logic               carry_q,     carry_d;
    logic               cout_q,      cout_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               a_msb_q,     a_msb_d;
    logic               b_msb_q,     b_msb_d;
    logic               ovf_q,       ovf_d;
`endif

    // The single shared adder slice: low chunk of each operand plus carry.
    logic [CHUNK:0]     w_slice;
    logic [WIDTH-1:0]   w_sum_next;
    logic               w_last;

    assign w_slice = {1'b0, a_sh_q[CHUNK-1:0]}
                   + {1'b0, b_sh_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};

    assign w_last = (cnt_q == CNT_W'(NCHUNK - 1));

    // New chunk enters at the MSB end, so after NCHUNK cycles the first
    // chunk computed has travelled down to [CHUNK-1:0].
    generate
        if (CHUNK == WIDTH) begin : g_sum_full
            assign w_sum_next = w_slice[CHUNK-1:0];
        end else begin : g_sum_part
            assign w_sum_next = {w_slice[CHUNK-1:0], sum_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SERIAL_ADDER_OVF_EN
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d     = a;
                    b_sh_d     = b;
                    carry_d    = cin;   // each operation starts from its own cin
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_BUSY;
`ifdef SERIAL_ADDER_OVF_EN
                    a_msb_d    = a[WIDTH-1];
                    b_msb_d    = b[WIDTH-1];
`endif
                end
            end
            S_BUSY: begin
                a_sh_d  = a_sh_q >> CHUNK;
                b_sh_d  = b_sh_q >> CHUNK;
                sum_d   = w_sum_next;
                carry_d = w_slice[CHUNK];
                cnt_d   = cnt_q + CNT_W'(1);
                if (w_last) begin
                    cout_d      = w_slice[CHUNK];
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    // Final slice MSB is the sum MSB.
                    ovf_d = (a_msb_q == b_msb_q) && (w_slice[CHUNK-1] != a_msb_q);
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;   // ready is visible even while in reset
            out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
`default_nettype wire
